// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and execute-side resolution bundle shared by the CPU pipeline
// and the branch predictor.
interface branch_predictor_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] if_pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_next_pc;

    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            upd_is_branch;
    logic            upd_is_jump;
    logic            upd_taken;
    logic [XLEN-1:0] upd_target;
    logic            upd_pred_taken;
    logic [XLEN-1:0] upd_pred_next_pc;
    logic            upd_mispredict;

    logic [31:0]     branch_cnt;
    logic [31:0]     mispred_cnt;

    modport master (
        output if_pc, upd_valid, upd_pc, upd_is_branch, upd_is_jump, upd_taken,
               upd_target, upd_pred_taken, upd_pred_next_pc,
        input  pred_taken, pred_next_pc, upd_mispredict, branch_cnt, mispred_cnt
    );

    modport slave (
        input  if_pc, upd_valid, upd_pc, upd_is_branch, upd_is_jump, upd_taken,
               upd_target, upd_pred_taken, upd_pred_next_pc,
        output pred_taken, pred_next_pc, upd_mispredict, branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB plus 2-bit counter direction predictor (static / bimodal / gshare).
// Lookup is combinational from if_pc; training and mispredict accounting happen at EX resolution.
module branch_predictor #(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 32,
    parameter int GHR_BITS = 5,
    parameter int MODE     = 2
) (
    input  logic              clk,
    input  logic              reset,
    branch_predictor_if.slave bus
);
    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = XLEN - IDX - 2;

    logic                valid_q   [ENTRIES];
    logic                is_jump_q [ENTRIES];
    logic [TAGW-1:0]     tag_q     [ENTRIES];
    logic [XLEN-1:0]     target_q  [ENTRIES];
    logic [1:0]          cnt_q     [ENTRIES];
    logic [GHR_BITS-1:0] ghr_q;
    logic [31:0]         branch_q;
    logic [31:0]         mispred_q;

    logic [IDX-1:0]  hist;
    logic [IDX-1:0]  lk_bidx;
    logic [IDX-1:0]  lk_pidx;
    logic [TAGW-1:0] lk_tag;
    logic            lk_hit;
    logic [IDX-1:0]  up_bidx;
    logic [IDX-1:0]  up_pidx;
    logic [TAGW-1:0] up_tag;
    logic [XLEN-1:0] actual_next;
    logic            do_upd;
    logic            unused_ok;

    // History only folds into the counter index in gshare mode.
    assign hist    = (MODE == 2) ? IDX'(ghr_q) : '0;

    assign lk_bidx = bus.if_pc[IDX+1:2];
    assign lk_tag  = bus.if_pc[XLEN-1:IDX+2];
    assign lk_pidx = lk_bidx ^ hist;
    assign lk_hit  = valid_q[lk_bidx] && (tag_q[lk_bidx] == lk_tag);

    assign bus.pred_taken   = (MODE != 0) && lk_hit && (is_jump_q[lk_bidx] || cnt_q[lk_pidx][1]);
    assign bus.pred_next_pc = bus.pred_taken ? target_q[lk_bidx] : bus.if_pc + XLEN'(4);

    assign up_bidx = bus.upd_pc[IDX+1:2];
    assign up_tag  = bus.upd_pc[XLEN-1:IDX+2];
    assign up_pidx = up_bidx ^ hist;

    assign actual_next        = bus.upd_taken ? bus.upd_target : bus.upd_pc + XLEN'(4);
    assign bus.upd_mispredict = bus.upd_valid && (actual_next != bus.upd_pred_next_pc);
    assign do_upd             = bus.upd_valid && (bus.upd_is_branch || bus.upd_is_jump);

    assign bus.branch_cnt  = branch_q;
    assign bus.mispred_cnt = mispred_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]   <= 1'b0;
                is_jump_q[i] <= 1'b0;
                tag_q[i]     <= '0;
                target_q[i]  <= '0;
                cnt_q[i]     <= 2'b01;
            end
            ghr_q <= '0;
        end else if (do_upd && (MODE != 0)) begin
            if (bus.upd_is_branch) begin
                if (bus.upd_taken && (cnt_q[up_pidx] != 2'b11))
                    cnt_q[up_pidx] <= cnt_q[up_pidx] + 2'b01;
                else if (!bus.upd_taken && (cnt_q[up_pidx] != 2'b00))
                    cnt_q[up_pidx] <= cnt_q[up_pidx] - 2'b01;
                if (MODE == 2)
                    ghr_q <= GHR_BITS'({ghr_q, bus.upd_taken});
            end
            // Not-taken outcomes leave the BTB alone; taken ones replace whatever sits in the slot.
            if (bus.upd_taken) begin
                valid_q[up_bidx]   <= 1'b1;
                tag_q[up_bidx]     <= up_tag;
                target_q[up_bidx]  <= bus.upd_target;
                is_jump_q[up_bidx] <= bus.upd_is_jump;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_q  <= '0;
            mispred_q <= '0;
        end else if (do_upd) begin
            if (branch_q != 32'hFFFF_FFFF)
                branch_q <= branch_q + 32'd1;
            if (bus.upd_mispredict && (mispred_q != 32'hFFFF_FFFF))
                mispred_q <= mispred_q + 32'd1;
        end
    end

    // PC alignment bits and the carried prediction bit play no role in the decisions.
    assign unused_ok = ^{bus.upd_pred_taken, bus.if_pc[1:0], bus.upd_pc[1:0]};
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: bimodal, gshare and static instances share one stimulus stream.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] if_pc = 32'h0;
    logic        upd_valid = 1'b0, upd_is_branch = 1'b0, upd_is_jump = 1'b0;
    logic        upd_taken = 1'b0, upd_pred_taken = 1'b0;
    logic [31:0] upd_pc = 32'h0, upd_target = 32'h0, upd_pred_next_pc = 32'h4;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] obs_q[$];

    localparam logic        GS_TK   [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam logic [31:0] GS_PRED [8] = '{32'h44, 32'h44, 32'h44, 32'h44, 32'h20, 32'h44, 32'h20, 32'h44};
    localparam logic        GS_MIS  [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    always #5 clk = ~clk;

    branch_predictor_if #(.XLEN(32)) bus0 ();
    branch_predictor_if #(.XLEN(32)) bus1 ();
    branch_predictor_if #(.XLEN(32)) bus2 ();

    assign bus0.if_pc = if_pc;  assign bus1.if_pc = if_pc;  assign bus2.if_pc = if_pc;
    assign bus0.upd_valid = upd_valid;  assign bus1.upd_valid = upd_valid;  assign bus2.upd_valid = upd_valid;
    assign bus0.upd_pc = upd_pc;  assign bus1.upd_pc = upd_pc;  assign bus2.upd_pc = upd_pc;
    assign bus0.upd_is_branch = upd_is_branch;  assign bus1.upd_is_branch = upd_is_branch;  assign bus2.upd_is_branch = upd_is_branch;
    assign bus0.upd_is_jump = upd_is_jump;  assign bus1.upd_is_jump = upd_is_jump;  assign bus2.upd_is_jump = upd_is_jump;
    assign bus0.upd_taken = upd_taken;  assign bus1.upd_taken = upd_taken;  assign bus2.upd_taken = upd_taken;
    assign bus0.upd_target = upd_target;  assign bus1.upd_target = upd_target;  assign bus2.upd_target = upd_target;
    assign bus0.upd_pred_taken = upd_pred_taken;  assign bus1.upd_pred_taken = upd_pred_taken;  assign bus2.upd_pred_taken = upd_pred_taken;
    assign bus0.upd_pred_next_pc = upd_pred_next_pc;  assign bus1.upd_pred_next_pc = upd_pred_next_pc;  assign bus2.upd_pred_next_pc = upd_pred_next_pc;

    branch_predictor #(.XLEN(32), .ENTRIES(32), .GHR_BITS(5), .MODE(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
    branch_predictor #(.XLEN(32), .ENTRIES(32), .GHR_BITS(5), .MODE(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
    branch_predictor #(.XLEN(32), .ENTRIES(32), .GHR_BITS(2), .MODE(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

    function automatic void push_exp(input string name, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.val  = v;
        exp_q.push_back(e);
    endfunction

    task automatic drive_upd(input logic v, input logic br, input logic jmp, input logic tk,
                             input logic [31:0] pc, input logic [31:0] tgt, input logic [31:0] pnpc);
        upd_valid        = v;
        upd_is_branch    = br;
        upd_is_jump      = jmp;
        upd_taken        = tk;
        upd_pc           = pc;
        upd_target       = tgt;
        upd_pred_next_pc = pnpc;
        upd_pred_taken   = (pnpc != pc + 32'd4);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        drive_upd(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h4);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [31:0] o;
        #2;
        reset = 1'b1;
        if_pc = 32'h100;
        push_exp("rst_pred_taken", 32'h0);
        push_exp("rst_next_pc_bimodal", 32'h104);
        push_exp("rst_next_pc_gshare", 32'h104);
        #1;
        obs_q.push_back(32'(bus1.pred_taken));
        obs_q.push_back(bus1.pred_next_pc);
        obs_q.push_back(bus2.pred_next_pc);
        @(negedge clk);
        reset = 1'b0;
        push_exp("rel_next_pc", 32'h104);
        push_exp("rel_branch_cnt", 32'h0);
        push_exp("rel_mispred_cnt", 32'h0);
        #1;
        obs_q.push_back(bus1.pred_next_pc);
        obs_q.push_back(bus1.branch_cnt);
        obs_q.push_back(bus1.mispred_cnt);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : 32'hDEAD_BEEF;
            checks++;
            if (o !== e.val) begin
                failures++;
                $display("FAIL %s: got %0h expected %0h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_bimodal();
        exp_t e;
        logic [31:0] o;
        apply_reset();
        @(negedge clk);
        if_pc = 32'h40;
        drive_upd(1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 32'h20, 32'h44);
        push_exp("bim_first_mispredict", 32'h1);
        push_exp("bim_pre_alloc_next_pc", 32'h44);
        #1;
        obs_q.push_back(32'(bus1.upd_mispredict));
        obs_q.push_back(bus1.pred_next_pc);
        @(negedge clk);
        drive_upd(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h4);
        push_exp("bim_trained_taken", 32'h1);
        push_exp("bim_trained_next_pc", 32'h20);
        #1;
        obs_q.push_back(32'(bus1.pred_taken));
        obs_q.push_back(bus1.pred_next_pc);
        @(negedge clk);
        drive_upd(1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 32'h20, 32'h20);
        push_exp("bim_second_mispredict", 32'h0);
        #1;
        obs_q.push_back(32'(bus1.upd_mispredict));
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive_upd(1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h20, 32'h20);
            push_exp("bim_not_taken_mispredict", 32'h1);
            #1;
            obs_q.push_back(32'(bus1.upd_mispredict));
        end
        @(negedge clk);
        drive_upd(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h4);
        push_exp("bim_untrained_taken", 32'h0);
        push_exp("bim_untrained_next_pc", 32'h44);
        push_exp("bim_branch_cnt", 32'd4);
        push_exp("bim_mispred_cnt", 32'd3);
        #1;
        obs_q.push_back(32'(bus1.pred_taken));
        obs_q.push_back(bus1.pred_next_pc);
        obs_q.push_back(bus1.branch_cnt);
        obs_q.push_back(bus1.mispred_cnt);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : 32'hDEAD_BEEF;
            checks++;
            if (o !== e.val) begin
                failures++;
                $display("FAIL %s: got %0h expected %0h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        logic [31:0] o;
        apply_reset();
        if_pc = 32'h40;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive_upd(1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 32'h20, 32'h20);
        end
        // Lookup during each not-taken update shows the counter left by the previous edge: 11,10,01,00,00.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive_upd(1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h20, 32'h44);
            push_exp("sat_down_next_pc", (i < 2) ? 32'h20 : 32'h44);
            #1;
            obs_q.push_back(bus1.pred_next_pc);
        end
        @(negedge clk);
        drive_upd(1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 32'h20, 32'h20);
        push_exp("sat_floor_next_pc", 32'h44);
        push_exp("sat_branch_cnt", 32'd10);
        push_exp("sat_mispred_cnt", 32'd0);
        #1;
        obs_q.push_back(bus1.pred_next_pc);
        obs_q.push_back(bus1.branch_cnt);
        obs_q.push_back(bus1.mispred_cnt);
        @(negedge clk);
        drive_upd(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h4);
        push_exp("sat_after_floor_next_pc", 32'h44);
        #1;
        obs_q.push_back(bus1.pred_next_pc);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : 32'hDEAD_BEEF;
            checks++;
            if (o !== e.val) begin
                failures++;
                $display("FAIL %s: got %0h expected %0h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_jump_alias();
        exp_t e;
        logic [31:0] o;
        apply_reset();
        @(negedge clk);
        drive_upd(1'b1, 1'b0, 1'b1, 1'b1, 32'h80, 32'h200, 32'h84);
        push_exp("jal_mispredict", 32'h1);
        #1;
        obs_q.push_back(32'(bus1.upd_mispredict));
        @(negedge clk);
        if_pc = 32'h80;
        drive_upd(1'b1, 1'b0, 1'b0, 1'b1, 32'h80, 32'h400, 32'h84);
        push_exp("untyped_mispredict", 32'h1);
        push_exp("jal_lookup_next_pc", 32'h200);
        #1;
        obs_q.push_back(32'(bus1.upd_mispredict));
        obs_q.push_back(bus1.pred_next_pc);
        @(negedge clk);
        drive_upd(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h4);
        push_exp("untyped_no_write", 32'h200);
        #1;
        obs_q.push_back(bus1.pred_next_pc);
        if_pc = 32'h100;
        push_exp("alias_miss_taken", 32'h0);
        push_exp("alias_miss_next_pc", 32'h104);
        push_exp("jal_branch_cnt", 32'd1);
        push_exp("jal_mispred_cnt", 32'd1);
        #1;
        obs_q.push_back(32'(bus1.pred_taken));
        obs_q.push_back(bus1.pred_next_pc);
        obs_q.push_back(bus1.branch_cnt);
        obs_q.push_back(bus1.mispred_cnt);
        @(negedge clk);
        drive_upd(1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h300, 32'h104);
        @(negedge clk);
        drive_upd(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h4);
        if_pc = 32'h80;
        push_exp("evicted_next_pc", 32'h84);
        #1;
        obs_q.push_back(bus1.pred_next_pc);
        if_pc = 32'h100;
        push_exp("evictor_next_pc", 32'h300);
        push_exp("evict_branch_cnt", 32'd2);
        push_exp("evict_mispred_cnt", 32'd2);
        #1;
        obs_q.push_back(bus1.pred_next_pc);
        obs_q.push_back(bus1.branch_cnt);
        obs_q.push_back(bus1.mispred_cnt);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : 32'hDEAD_BEEF;
            checks++;
            if (o !== e.val) begin
                failures++;
                $display("FAIL %s: got %0h expected %0h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic [31:0] o;
        @(negedge clk);
        if_pc = 32'h100;
        push_exp("mid_before_next_pc", 32'h300);
        #1;
        obs_q.push_back(bus1.pred_next_pc);
        #1;
        reset = 1'b1;
        push_exp("mid_rst_next_pc", 32'h104);
        push_exp("mid_rst_branch_cnt", 32'd0);
        push_exp("mid_rst_mispred_cnt", 32'd0);
        #1;
        obs_q.push_back(bus1.pred_next_pc);
        obs_q.push_back(bus1.branch_cnt);
        obs_q.push_back(bus1.mispred_cnt);
        @(negedge clk);
        reset = 1'b0;
        push_exp("mid_rel_next_pc", 32'h104);
        #1;
        obs_q.push_back(bus1.pred_next_pc);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : 32'hDEAD_BEEF;
            checks++;
            if (o !== e.val) begin
                failures++;
                $display("FAIL %s: got %0h expected %0h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_gshare();
        exp_t e;
        logic [31:0] o;
        apply_reset();
        if_pc = 32'h40;
        // Alternating outcomes map onto pattern entries 16,17,18,17,18,... once history warms up.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive_upd(1'b1, 1'b1, 1'b0, GS_TK[i], 32'h40, 32'h20, GS_PRED[i]);
            push_exp($sformatf("gs_next_pc_%0d", i), GS_PRED[i]);
            push_exp($sformatf("gs_mispredict_%0d", i), 32'(GS_MIS[i]));
            #1;
            obs_q.push_back(bus2.pred_next_pc);
            obs_q.push_back(32'(bus2.upd_mispredict));
        end
        @(negedge clk);
        drive_upd(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h4);
        push_exp("gs_branch_cnt", 32'd8);
        push_exp("gs_mispred_cnt", 32'd2);
        #1;
        obs_q.push_back(bus2.branch_cnt);
        obs_q.push_back(bus2.mispred_cnt);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : 32'hDEAD_BEEF;
            checks++;
            if (o !== e.val) begin
                failures++;
                $display("FAIL %s: got %0h expected %0h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [31:0] o;
        apply_reset();
        @(negedge clk);
        if_pc = 32'h40;
        drive_upd(1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 32'h20, 32'h44);
        push_exp("b2b_same_edge_next_pc", 32'h44);
        #1;
        obs_q.push_back(bus1.pred_next_pc);
        @(negedge clk);
        drive_upd(1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 32'h20, 32'h20);
        push_exp("b2b_next_cycle_taken", 32'h1);
        push_exp("b2b_next_cycle_next_pc", 32'h20);
        #1;
        obs_q.push_back(32'(bus1.pred_taken));
        obs_q.push_back(bus1.pred_next_pc);
        @(negedge clk);
        drive_upd(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h4);
        push_exp("b2b_settled_next_pc", 32'h20);
        #1;
        obs_q.push_back(bus1.pred_next_pc);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : 32'hDEAD_BEEF;
            checks++;
            if (o !== e.val) begin
                failures++;
                $display("FAIL %s: got %0h expected %0h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_mode0();
        exp_t e;
        logic [31:0] o;
        logic [31:0] pcs [4];
        logic        tks [4];
        logic        jmps [4];
        pcs  = '{32'h40, 32'h40, 32'h80, 32'h40};
        tks  = '{1'b1, 1'b1, 1'b1, 1'b0};
        jmps = '{1'b0, 1'b0, 1'b1, 1'b0};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if_pc = pcs[i];
            drive_upd(1'b1, !jmps[i], jmps[i], tks[i], pcs[i], 32'h20, pcs[i] + 32'd4);
            push_exp($sformatf("static_pred_taken_%0d", i), 32'h0);
            #1;
            obs_q.push_back(32'(bus0.pred_taken));
        end
        @(negedge clk);
        drive_upd(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h4);
        if_pc = 32'h80;
        push_exp("static_next_pc", 32'h84);
        push_exp("static_branch_cnt", 32'd4);
        push_exp("static_mispred_cnt", 32'd3);
        #1;
        obs_q.push_back(bus0.pred_next_pc);
        obs_q.push_back(bus0.branch_cnt);
        obs_q.push_back(bus0.mispred_cnt);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : 32'hDEAD_BEEF;
            checks++;
            if (o !== e.val) begin
                failures++;
                $display("FAIL %s: got %0h expected %0h", e.name, o, e.val);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_bimodal();
        test_saturation();
        test_jump_alias();
        test_reset_mid();
        test_gshare();
        test_back_to_back();
        test_mode0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised branch target buffer (BTB) plus 2-bit saturating-counter direction predictor for the pipelined RISC-V CPU.
- Lookup is combinational in IF from the current PC and supplies next-PC.
- Update and misprediction detection happen at branch resolution in EX; the mispredict flag drives the pipeline flush.
- Supports three modes: static not-taken, bimodal and gshare. It replaces the fixed PC+4 adder path.

Parameters:
- XLEN, 32, address/data width.
- ENTRIES, 32, BTB and pattern-table depth; must be a power of 2, at least 4. IDX = log2(ENTRIES).
- GHR_BITS, 5, global history length; must be 1..IDX.
- MODE, 2, 0 = static not-taken, 1 = bimodal, 2 = gshare.

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- if_pc  in  XLEN  PC being fetched.
- pred_taken  out  1  predicted taken for if_pc.
- pred_next_pc  out  XLEN  predicted next PC.
- upd_valid  in  1  resolved control-flow instruction present in EX.
- upd_pc  in  XLEN  PC of the resolved instruction.
- upd_is_branch  in  1  conditional branch.
- upd_is_jump  in  1  jal/jalr.
- upd_taken  in  1  actual outcome; must be 1 for jumps.
- upd_target  in  XLEN  actual target.
- upd_pred_taken  in  1  prediction carried down the pipe.
- upd_pred_next_pc  in  XLEN  predicted next PC carried down the pipe.
- upd_mispredict  out  1  flush request.
- branch_cnt  out  32  resolved branches and jumps.
- mispred_cnt  out  32  mispredictions.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset, applied immediately including mid-operation:
  - all BTB valid bits 0;
  - all counters 2'b01 (weakly not-taken);
  - GHR 0;
  - branch_cnt and mispred_cnt 0.
  - Consequence: pred_taken = 0 and pred_next_pc = if_pc + 4 while reset is asserted and right after release.
- Indexing:
  - bidx = pc[IDX+1:2]; tag = pc[XLEN-1:IDX+2].
  - pidx = bidx in MODE 1; bidx XOR zero-extended GHR in MODE 2.
- Lookup (combinational, zero latency):
  - hit = valid[bidx] && tag match.
  - pred_taken = hit && (entry.is_jump || cnt[pidx][1]).
  - pred_next_pc = pred_taken ? entry.target : if_pc + 4, with wrap modulo 2^XLEN.
  - MODE 0: pred_taken is always 0.
- upd_mispredict (combinational) = upd_valid && ((upd_taken ? upd_target : upd_pc + 4) != upd_pred_next_pc).
  - Defined for every instruction type.
  - Independent of upd_pred_taken.
- Update on posedge when upd_valid && (upd_is_branch || upd_is_jump):
  - Counter, branches only: cnt[pidx(upd_pc, GHR before shift)] saturating.
    - Taken: +1, capped at 2'b11.
    - Not taken: -1, floored at 2'b00.
  - GHR, MODE 2 only: shifts left with upd_taken as the LSB, branches only.
  - BTB, when upd_taken: entry[bidx] <= {valid = 1, tag, upd_target, is_jump = upd_is_jump}.
    - Overwrites any conflicting entry (direct-mapped replacement).
    - A not-taken outcome never allocates or invalidates an entry.
  - MODE 0: tables and GHR stay at reset values.
  - branch_cnt += 1.
  - mispred_cnt += upd_mispredict.
  - Both counters saturate at 32'hFFFF_FFFF.
- upd_valid with neither type flag asserted: no state change; upd_mispredict is still computed.
- Simultaneous lookup and update at the same index: lookup sees pre-edge state; no bypass.
- if_pc and upd_pc are assumed word-aligned; bits [1:0] are ignored.

Test Plan:
1. Reset, then if_pc = 0x100 -> pred_taken = 0, pred_next_pc = 0x104. Assert reset mid-run after entries are written -> lookups return PC+4 immediately, counters read 0.
2. MODE 1, branch at 0x40 to 0x20, taken twice:
   - 1st update: upd_pred_next_pc = 0x44 -> upd_mispredict = 1, BTB allocated, counter 01->10.
   - Next lookup of 0x40 -> pred_next_pc = 0x20.
   - 2nd update with prediction 0x20 -> upd_mispredict = 0, counter 11.
   - Two not-taken updates -> counter 01, lookup gives 0x44.
3. Saturation: 5 taken updates -> counter holds 2'b11. 5 not-taken updates -> holds 2'b00. branch_cnt = 10.
4. jal at 0x80 to 0x200, ENTRIES = 32:
   - Update -> lookup of 0x80 predicts 0x200 with counters at reset.
   - Aliasing PC 0x80 + 0x80 = 0x100 -> tag miss, PC+4.
   - Taken update at 0x100 evicts 0x80.
5. MODE 2, GHR_BITS = 2, branch pattern T,N,T,N at one PC:
   - GHR sequence 00 -> 01 -> 10 -> 01 -> 10.
   - Distinct counters are trained.
   - After warm-up, mispred_cnt stops incrementing.
6. Same-edge update and lookup of the same PC -> lookup output equals pre-update prediction that cycle, new prediction on the next cycle. MODE 0 -> pred_taken never 1, mispred_cnt counts every taken branch.
